// File: rtl/datamem_responder.sv
// Multi-cycle data-memory responder: accepts one word read/write at a time,
// inserts WAIT_CYCLES wait states, then completes with a one-cycle ack
// (plus err for misaligned or out-of-range addresses).
//
// Handshake: the requester raises req with stable we/addr/wdata and holds
// them until ack. The request is captured on the accept edge (IDLE and req
// high); later changes to the inputs do not affect the access in flight.
// ack is a single-cycle pulse and err is meaningful only while ack is high.
// A req still high during the ack cycle is not accepted; the next accept is
// earliest on the following edge, once the block is back in IDLE.
`timescale 1ns/1ps
module datamem_responder #(
  parameter int          DEPTH_LOG2  = 6,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  // Byte size of the store; 33 bits so large depths cannot overflow.
  localparam logic [32:0] LIMIT     = 33'd4 << DEPTH_LOG2;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic                  enter_resp;
  logic                  op_we;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  op_err;

  // Decide whether this edge performs the memory operation. With zero wait
  // states the access happens on the accept edge, so use the live inputs;
  // otherwise use the captured request.
  always_comb begin
    enter_resp = ((state == IDLE) && req && ZERO_WAIT) ||
                 ((state == WAIT) && (cnt == 4'd1));
    op_we    = cap_we;
    op_addr  = cap_addr;
    op_wdata = cap_wdata;
    if (state == IDLE) begin
      op_we    = we;
      op_addr  = addr;
      op_wdata = wdata;
    end
    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    off    = op_addr - BASE_ADDR;
    idx    = off[DEPTH_LOG2+1:2];
    op_err = (op_addr[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
  end

  // Word store, not reset; a write commits only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_we && !op_err) begin
      mem[idx] <= op_wdata;
    end
  end

  // Control FSM with registered ack/err/busy/rdata and request capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            busy      <= 1'b1;
            if (ZERO_WAIT) begin
              state <= RESP;
              ack   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      // Completion: report the error and update rdata for reads.
      if (enter_resp) begin
        err <= op_err;
        if (!op_we) begin
          rdata <= op_err ? 32'h0 : mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench for datamem_responder: three instances cover the default
// configuration, zero wait states and a non-zero base address.
`timescale 1ns/1ps
module tb_datamem_responder;

  logic        clk;
  logic        rst;
  logic        req_v   [3];
  logic        we_v    [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic [31:0] rdata_v [3];
  logic        ack_v   [3];
  logic        err_v   [3];
  logic        busy_v  [3];

  int n_cmp;
  int n_bad;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  datamem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dflt (
    .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]),
    .busy(busy_v[0]));

  datamem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_zero (
    .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]),
    .busy(busy_v[1]));

  datamem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .BASE_ADDR(32'h1000_0000)) u_base (
    .clk(clk), .rst(rst), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
    .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ack(ack_v[2]), .err(err_v[2]),
    .busy(busy_v[2]));

  // Scoreboard check: count, report mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: one complete access; returns data, err and the edge count
  // from the accept edge (counted as 1) to the edge that raised ack.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic e, output int lat);
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
    @(posedge clk);
    lat = 1;
    #1;
    while (!ack_v[d] && lat < 20) begin
      check("busy_wait", 32'(busy_v[d]), 32'd1);
      @(posedge clk);
      lat++;
      #1;
    end
    check("ack_seen", 32'(ack_v[d]), 32'd1);
    check("busy_ack", 32'(busy_v[d]), 32'd1);
    rd = rdata_v[d];
    e  = err_v[d];
    req_v[d] = 1'b0;
    @(posedge clk);
    #1;
    check("ack_width", 32'(ack_v[d]), 32'd0);
    check("err_idle", 32'(err_v[d]), 32'd0);
    check("busy_idle", 32'(busy_v[d]), 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [5:0]  ack_pat;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = 32'h0; wdata_v[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_ack", 32'(ack_v[i]), 32'd0);
      check("rst_err", 32'(err_v[i]), 32'd0);
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_rdata", rdata_v[i], 32'h0);
    end

    // Basic write/read, default wait states
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_err", 32'(e), 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, rd, e, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_err", 32'(e), 32'd0);
    check("rd_data", rd, 32'hDEAD_BEEF);

    // Zero wait states
    access(1, 1'b1, 32'hFC, 32'h1234_5678, rd, e, lat);
    check("z_wr_lat", 32'(lat), 32'd1);
    check("z_wr_err", 32'(e), 32'd0);
    access(1, 1'b0, 32'hFC, 32'h0, rd, e, lat);
    check("z_rd_lat", 32'(lat), 32'd1);
    check("z_rd_data", rd, 32'h1234_5678);

    // Zero wait, req held: accepts every second edge
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 32'hFC;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      ack_pat[i] = ack_v[1];
    end
    req_v[1] = 1'b0;
    check("z_b2b_pattern", 32'(ack_pat), 32'h15);
    check("z_b2b_data", rdata_v[1], 32'h1234_5678);
    @(posedge clk);

    // Misaligned and out-of-range
    access(0, 1'b1, 32'h12, 32'h1, rd, e, lat);
    check("mis_wr_err", 32'(e), 32'd1);
    access(0, 1'b0, 32'h100, 32'h0, rd, e, lat);
    check("oor_rd_err", 32'(e), 32'd1);
    check("oor_rd_data", rd, 32'h0);
    access(0, 1'b0, 32'h10, 32'h0, rd, e, lat);
    check("untouched_err", 32'(e), 32'd0);
    check("untouched_data", rd, 32'hDEAD_BEEF);

    // Reset in the middle of a write
    access(0, 1'b1, 32'h20, 32'h0, rd, e, lat);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    check("mid_busy", 32'(busy_v[0]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_v[0] = 1'b0;
    #1;
    check("arst_busy", 32'(busy_v[0]), 32'd0);
    check("arst_ack", 32'(ack_v[0]), 32'd0);
    check("arst_err", 32'(err_v[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b0, 32'h20, 32'h0, rd, e, lat);
    check("abort_data", rd, 32'h0);
    check("abort_err", 32'(e), 32'd0);

    // Held req with address change during WAIT
    access(0, 1'b1, 32'h30, 32'h1111_1111, rd, e, lat);
    access(0, 1'b1, 32'h34, 32'h2222_2222, rd, e, lat);
    @(negedge clk);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h30;
    @(posedge clk);
    #1;
    check("hold_busy1", 32'(busy_v[0]), 32'd1);
    addr_v[0] = 32'h34;
    @(posedge clk);
    #1;
    check("hold_busy2", 32'(busy_v[0]), 32'd1);
    check("hold_noack", 32'(ack_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("hold_ack1", 32'(ack_v[0]), 32'd1);
    check("hold_data1", rdata_v[0], 32'h1111_1111);
    check("hold_busy3", 32'(busy_v[0]), 32'd1);
    @(posedge clk);
    #1;
    check("hold_idle_busy", 32'(busy_v[0]), 32'd0);
    check("hold_idle_ack", 32'(ack_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("hold_acc2_busy", 32'(busy_v[0]), 32'd1);
    check("hold_acc2_ack", 32'(ack_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("hold_w2_ack", 32'(ack_v[0]), 32'd0);
    @(posedge clk);
    #1;
    check("hold_ack2", 32'(ack_v[0]), 32'd1);
    check("hold_data2", rdata_v[0], 32'h2222_2222);
    req_v[0] = 1'b0;
    @(posedge clk);
    #1;
    check("hold_end_busy", 32'(busy_v[0]), 32'd0);

    // Non-zero base address
    access(2, 1'b0, 32'h0FFF_FFFC, 32'h0, rd, e, lat);
    check("base_below_err", 32'(e), 32'd1);
    check("base_below_data", rd, 32'h0);
    access(2, 1'b1, 32'h1000_0004, 32'hCAFE_F00D, rd, e, lat);
    check("base_wr_err", 32'(e), 32'd0);
    access(2, 1'b0, 32'h1000_0004, 32'h0, rd, e, lat);
    check("base_rd_err", 32'(e), 32'd0);
    check("base_rd_data", rd, 32'hCAFE_F00D);
    check("base_rd_lat", 32'(lat), 32'd3);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
